// File: rtl/reel_pixel_gen_if.sv
// reel_pixel_gen_if: timing/control inputs and pixel/status outputs of the reel pixel generator
interface reel_pixel_gen_if;
  logic [10:0] hcount;
  logic [9:0]  vcount;
  logic        active_video;
  logic        hsync_in;
  logic        vsync_in;
  logic        start;
  logic [2:0]  stop_req;
  logic [8:0]  stop_sym;
  logic [11:0] rgb;
  logic        hsync_out;
  logic        vsync_out;
  logic [2:0]  reel_done;
  logic        busy;
  modport master (
    output hcount, vcount, active_video, hsync_in, vsync_in, start, stop_req, stop_sym,
    input  rgb, hsync_out, vsync_out, reel_done, busy
  );
  modport slave (
    input  hcount, vcount, active_video, hsync_in, vsync_in, start, stop_req, stop_sym,
    output rgb, hsync_out, vsync_out, reel_done, busy
  );
endinterface

// File: rtl/reel_pixel_gen.sv
// reel_pixel_gen: three scrolling slot reels rendered over VGA timing, with per-reel spin/stop control
module reel_pixel_gen #(
  parameter int H_DISPLAY_START = 144,
  parameter int V_DISPLAY_START = 35,
  parameter int V_TICK_LINE     = 515,
  parameter int SPIN_SPEED      = 16
) (
  input logic             clk,
  input logic             reset_n,
  reel_pixel_gen_if.slave bus
);
  typedef enum logic [1:0] {IDLE, SPINNING, STOPPING, STOPPED} state_t;
  localparam logic [9:0] STEP = 10'(SPIN_SPEED);
  localparam logic [11:0] PAL [8] = '{12'hF00, 12'h0F0, 12'h00F, 12'hFF0,
                                      12'h0FF, 12'hF0F, 12'hFFF, 12'hF80};
  state_t      r_state [3];
  state_t      w_state_nx [3];
  logic [9:0]  r_offset [3];
  logic [9:0]  w_offset_nx [3];
  logic [9:0]  r_target [3];
  logic [9:0]  w_target_nx [3];
  logic [2:0]  r_done, w_done;
  logic        w_tick, w_busy;
  logic [10:0] w_x;
  logic [9:0]  w_y, w_ry, w_strip;
  logic        w_hit;
  logic [1:0]  w_idx;
  logic [6:0]  w_rx;
  logic        r_hit, r_av;
  logic [6:0]  r_rx;
  logic [9:0]  r_strip;
  logic [1:0]  r_hs, r_vs;
  logic [11:0] r_rgb, w_rgb;
  logic [2:0]  w_sym;
  logic [6:0]  w_cy;
  assign w_tick = bus.hcount == 11'd0 && bus.vcount == 10'(V_TICK_LINE);
  // any reel still in motion blocks a new start
  always_comb begin
    w_busy = 1'b0;
    for (int k = 0; k < 3; k++) w_busy = w_busy | r_state[k] == SPINNING | r_state[k] == STOPPING;
  end
  // per-reel next state: positions only move on the frame tick, inside vertical blank
  always_comb begin
    for (int k = 0; k < 3; k++) begin
      w_state_nx[k]  = r_state[k];
      w_offset_nx[k] = r_offset[k];
      w_target_nx[k] = r_target[k];
      w_done[k]      = 1'b0;
      case (r_state[k])
        IDLE, STOPPED: if (bus.start && !w_busy) w_state_nx[k] = SPINNING;
        SPINNING: begin
          if (w_tick) w_offset_nx[k] = r_offset[k] + STEP;
          if (bus.stop_req[k]) begin
            w_state_nx[k]  = STOPPING;
            w_target_nx[k] = {3'(bus.stop_sym[3*k +: 3] - 3'd1), 7'd0};
          end
        end
        STOPPING: if (w_tick) begin
          if (r_offset[k] == r_target[k]) begin
            w_state_nx[k] = STOPPED;
            w_done[k]     = 1'b1;
          end else w_offset_nx[k] = r_offset[k] + STEP;
        end
        default: ;
      endcase
    end
  end
  // reel state registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int k = 0; k < 3; k++) begin
        r_state[k]  <= IDLE;
        r_offset[k] <= '0;
        r_target[k] <= '0;
      end
      r_done <= '0;
    end else begin
      r_state  <= w_state_nx;
      r_offset <= w_offset_nx;
      r_target <= w_target_nx;
      r_done   <= w_done;
    end
  end
  assign w_x  = bus.hcount - 11'(H_DISPLAY_START);
  assign w_y  = bus.vcount - 10'(V_DISPLAY_START);
  assign w_ry = w_y - 10'd48;
  // window hit test; coordinates left of/above the display wrap to large values and miss
  always_comb begin
    w_hit = 1'b0;
    w_idx = 2'd0;
    w_rx  = 7'd0;
    for (int k = 0; k < 3; k++)
      if (w_x >= 11'(64 + 192 * k) && w_x <= 11'(191 + 192 * k)) begin
        w_hit = w_y >= 10'd48 && w_y <= 10'd431;
        w_idx = 2'(k);
        w_rx  = 7'(w_x - 11'(64 + 192 * k));
      end
  end
  assign w_strip = w_ry + r_offset[w_idx];
  assign w_sym   = r_strip[9:7];
  assign w_cy    = r_strip[6:0];
  assign w_rgb   = !r_av ? 12'h000 : !r_hit ? 12'h002 :
                   (r_rx >= 7'd16 && r_rx <= 7'd111 && w_cy >= 7'd16 && w_cy <= 7'd111) ? PAL[w_sym] : 12'h888;
  // two-stage pixel pipeline with matching sync delay
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_hit   <= 1'b0;
      r_av    <= 1'b0;
      r_rx    <= '0;
      r_strip <= '0;
      r_hs    <= 2'b11;
      r_vs    <= 2'b11;
      r_rgb   <= '0;
    end else begin
      r_hit   <= w_hit;
      r_av    <= bus.active_video;
      r_rx    <= w_rx;
      r_strip <= w_strip;
      r_hs    <= {r_hs[0], bus.hsync_in};
      r_vs    <= {r_vs[0], bus.vsync_in};
      r_rgb   <= w_rgb;
    end
  end
  assign bus.rgb       = r_rgb;
  assign bus.hsync_out = r_hs[1];
  assign bus.vsync_out = r_vs[1];
  assign bus.reel_done = r_done;
  assign bus.busy      = w_busy;
endmodule

// File: tb/tb_reel_pixel_gen.sv
// tb_reel_pixel_gen: directed checks of reel pixel output, sync delay and spin/stop control
module tb_reel_pixel_gen;
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  int n_chk = 0;
  int n_err = 0;
  logic [2:0] done_seen;
  logic [2:0] early;
  reel_pixel_gen_if bus ();
  reel_pixel_gen dut (.clk(clk), .reset_n(reset_n), .bus(bus.slave));
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic step(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic frame();
    bus.hcount = 11'd0;
    bus.vcount = 10'd515;
    bus.active_video = 1'b0;
    step();
    done_seen = bus.reel_done;
    bus.vcount = 10'd0;
    step();
  endtask
  task automatic frames(input int n);
    early = 3'b000;
    repeat (n) begin
      frame();
      early = early | done_seen;
    end
  endtask
  task automatic pix(input string tag, input logic [10:0] h, input logic [9:0] v, input logic [11:0] exp);
    bus.hcount = h;
    bus.vcount = v;
    bus.active_video = 1'b1;
    step(2);
    check(tag, bus.rgb, exp);
  endtask
  task automatic pulse_start();
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
  endtask
  initial begin
    bus.hcount = 0; bus.vcount = 0; bus.active_video = 0;
    bus.hsync_in = 1; bus.vsync_in = 1;
    bus.start = 0; bus.stop_req = 0; bus.stop_sym = 0;
    step(3);
    check("rst_rgb", bus.rgb, 12'h000);
    check("rst_hs", bus.hsync_out, 1);
    check("rst_vs", bus.vsync_out, 1);
    check("rst_done", bus.reel_done, 0);
    check("rst_busy", bus.busy, 0);
    check("rst_off0", dut.r_offset[0], 0);
    reset_n = 1'b1;
    step();
    bus.hcount = 11'd244; bus.vcount = 10'd133; bus.active_video = 1'b1;
    step();
    check("lat1", bus.rgb, 12'h000);
    step();
    check("lat2", bus.rgb, 12'hF00);
    pix("outside", 11'd164, 10'd133, 12'h002);
    pix("border", 11'd213, 10'd133, 12'h888);
    pix("reel2_sym0", 11'd628, 10'd133, 12'hF00);
    bus.active_video = 1'b0;
    step(2);
    check("blank", bus.rgb, 12'h000);
    bus.hsync_in = 1'b0;
    step();
    check("hs_d1", bus.hsync_out, 1);
    step();
    check("hs_d2", bus.hsync_out, 0);
    check("vs_hold", bus.vsync_out, 1);
    bus.hsync_in = 1'b1; bus.vsync_in = 1'b0;
    step(2);
    check("vs_d2", bus.vsync_out, 0);
    check("hs_back", bus.hsync_out, 1);
    bus.vsync_in = 1'b1;
    step(2);
    bus.stop_req = 3'b001; bus.stop_sym = 9'd5;
    step();
    bus.stop_req = 0; bus.stop_sym = 0;
    check("idle_stop", bus.busy, 0);
    pulse_start();
    check("start_busy", bus.busy, 1);
    frames(8);
    check("spin_off0", dut.r_offset[0], 128);
    check("spin_off2", dut.r_offset[2], 128);
    pix("spin_sym1", 11'd244, 10'd133, 12'h0F0);
    pulse_start();
    check("busy_start_off", dut.r_offset[0], 128);
    check("busy_start_st", dut.r_state[0], 1);
    bus.stop_req = 3'b001; bus.stop_sym = 9'd5;
    step();
    bus.stop_req = 0; bus.stop_sym = 0;
    frames(24);
    check("r0_no_early", early, 0);
    check("r0_at_target", dut.r_offset[0], 512);
    frame();
    check("r0_done", done_seen, 3'b001);
    check("r0_off", dut.r_offset[0], 512);
    check("r1_off", dut.r_offset[1], 528);
    step();
    check("r0_done_clr", bus.reel_done, 0);
    check("busy_partial", bus.busy, 1);
    frame();
    pix("r0_stopped_px", 11'd244, 10'd193, 12'h0FF);
    pix("r1_spin_px", 11'd436, 10'd193, 12'h888);
    frames(5);
    check("r1_pre", dut.r_offset[1], 624);
    bus.hcount = 11'd0; bus.vcount = 10'd515; bus.active_video = 1'b0;
    bus.stop_req = 3'b010; bus.stop_sym = 9'b000_110_000;
    step();
    bus.stop_req = 0; bus.stop_sym = 0;
    check("tick_stop_adv", dut.r_offset[1], 640);
    check("tick_stop_st", dut.r_state[1], 2);
    bus.vcount = 10'd0;
    step();
    frame();
    check("r1_done", done_seen, 3'b010);
    check("r1_no_adv", dut.r_offset[1], 640);
    bus.stop_req = 3'b100; bus.stop_sym = 9'b111_000_000;
    step();
    bus.stop_sym = 9'b001_000_000;
    step();
    bus.stop_req = 0; bus.stop_sym = 0;
    frames(7);
    check("r2_no_early", early, 0);
    check("r2_off", dut.r_offset[2], 768);
    check("r2_busy", bus.busy, 1);
    frame();
    check("r2_done", done_seen, 3'b100);
    check("all_idle", bus.busy, 0);
    pulse_start();
    check("restart_busy", bus.busy, 1);
    frames(3);
    pix("pre_rst_px", 11'd244, 10'd133, 12'h0FF);
    @(posedge clk);
    #2 reset_n = 1'b0;
    #1;
    check("mid_rst_rgb", bus.rgb, 12'h000);
    check("mid_rst_busy", bus.busy, 0);
    check("mid_rst_off0", dut.r_offset[0], 0);
    check("mid_rst_off1", dut.r_offset[1], 0);
    check("mid_rst_done", bus.reel_done, 0);
    step(2);
    reset_n = 1'b1;
    step();
    pulse_start();
    check("post_rst_busy", bus.busy, 1);
    frames(8);
    pix("post_rst_px", 11'd244, 10'd133, 12'h0F0);
    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end
endmodule
